// File: rtl/iccm_port_arb.sv
// Single-port ICCM arbiter: IFU fetch, LSU loads/stores and the boot/debug loader.
// Owns grant selection, fetch stall, return-data routing and the loader-mode sequence.
module iccm_port_arb #(
   parameter int LSU_MAX_CONSEC = 4,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ifu_req,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_stall,
   output logic [31:0]       ifu_rdata,
   output logic              ifu_rvalid,
   input  logic              ifu_flush,
   input  logic              lsu_req,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [31:0]       lsu_wdata,
   input  logic [3:0]        lsu_wstrb,
   output logic              lsu_gnt,
   output logic [31:0]       lsu_rdata,
   output logic              lsu_rvalid,
   input  logic              ldr_mode,
   output logic              ldr_active,
   input  logic              ldr_wr,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [31:0]       ldr_wdata,
   output logic [ADDR_W-1:0] iccm_addr,
   output logic              iccm_rd_en,
   output logic              iccm_wr_en,
   output logic [31:0]       iccm_wr_data,
   output logic [3:0]        iccm_wr_strb,
   input  logic [31:0]       iccm_rd_data
);

   localparam int CW = $clog2(LSU_MAX_CONSEC + 1);
   localparam logic [CW-1:0] CMAX = CW'(LSU_MAX_CONSEC);
   localparam logic [CW-1:0] CONE = CW'(1);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      DRAIN = 2'b01,
      LOAD  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IFU  = 2'b01,
      OWN_LSU  = 2'b10
   } own_t;

   state_t          state;
   own_t            owner;
   own_t            owner_nxt;
   logic [CW-1:0]   lsu_consec;

   logic            in_run;
   logic            in_load;
   logic            lsu_win;
   logic            gnt_ifu;
   logic            gnt_lsu;
   logic            ldr_go;
   logic            consec_sat;

   // ------------------------------------------------------------------
   // Grant selection
   // ------------------------------------------------------------------
   assign in_run     = (state == RUN) && !ldr_mode;
   assign in_load    = (state == LOAD);
   assign consec_sat = (lsu_consec == CMAX);

   // LSU wins unless the IFU has already waited out its quota
   assign lsu_win = lsu_req && !(ifu_req && consec_sat);

   assign gnt_lsu = in_run && lsu_win;
   assign gnt_ifu = in_run && ifu_req && !lsu_win;
   assign ldr_go  = in_load && ldr_wr;

   assign lsu_gnt    = gnt_lsu;
   assign ifu_stall  = ifu_req && !gnt_ifu;
   assign ldr_active = in_load;

   // ------------------------------------------------------------------
   // ICCM drive
   // ------------------------------------------------------------------
   always_comb begin
      iccm_addr    = '0;
      iccm_rd_en   = 1'b0;
      iccm_wr_en   = 1'b0;
      iccm_wr_data = '0;
      iccm_wr_strb = '0;
      unique case (1'b1)
         gnt_ifu: begin
            iccm_addr  = ifu_addr;
            iccm_rd_en = 1'b1;
         end
         gnt_lsu && !lsu_we: begin
            iccm_addr  = lsu_addr;
            iccm_rd_en = 1'b1;
         end
         gnt_lsu && lsu_we: begin
            iccm_addr    = lsu_addr;
            iccm_wr_en   = 1'b1;
            iccm_wr_data = lsu_wdata;
            iccm_wr_strb = lsu_wstrb;
         end
         ldr_go: begin
            iccm_addr    = ldr_addr;
            iccm_wr_en   = 1'b1;
            iccm_wr_data = ldr_wdata;
            iccm_wr_strb = 4'hF;
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Return ownership of the read issued this cycle
   // ------------------------------------------------------------------
   always_comb begin
      owner_nxt = OWN_NONE;
      unique case (1'b1)
         gnt_ifu && !ifu_flush: owner_nxt = OWN_IFU;
         gnt_lsu && !lsu_we:    owner_nxt = OWN_LSU;
         default:               owner_nxt = OWN_NONE;
      endcase
   end

   // A flush in the return cycle also kills the fetch data
   assign ifu_rvalid = (owner == OWN_IFU) && !ifu_flush;
   assign lsu_rvalid = (owner == OWN_LSU);
   assign ifu_rdata  = ifu_rvalid ? iccm_rd_data : 32'h0;
   assign lsu_rdata  = lsu_rvalid ? iccm_rd_data : 32'h0;

   // ------------------------------------------------------------------
   // Sequencer, fairness counter and owner register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         owner      <= OWN_NONE;
         lsu_consec <= '0;
      end else begin
         owner <= owner_nxt;

         if (gnt_ifu || !ifu_req)
            lsu_consec <= '0;
         else if (gnt_lsu && !consec_sat)
            lsu_consec <= lsu_consec + CONE;

         unique case (state)
            RUN: begin
               if (ldr_mode)
                  state <= DRAIN;
            end
            DRAIN: begin
               state <= ldr_mode ? LOAD : RUN;
            end
            LOAD: begin
               if (!ldr_mode)
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: doc/iccm_port_arb.md
# iccm_port_arb

Single-port ICCM arbiter and sequencer. Shares the ICCM port between three requesters: instruction fetch (IFU), LSU data loads/stores to ICCM space, and the boot/debug program loader. It sits between those masters and the ICCM macro, which has 1-cycle read latency. It owns grant selection, fetch stall, return-data routing, and the loader-mode sequence.

## Interface
- `LSU_MAX_CONSEC`, default 4: maximum consecutive LSU grants while the IFU is requesting; after that the IFU is granted one slot.
- `ADDR_W`, default 32: address width.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ifu_req` in 1: fetch request (IFU requests every cycle unless flushing).
- `ifu_addr` in ADDR_W: fetch address (current PC).
- `ifu_stall` out 1: fetch not granted this cycle; IFU must hold its PC.
- `ifu_rdata` out 32: fetch return data.
- `ifu_rvalid` out 1: `ifu_rdata` valid.
- `ifu_flush` in 1: branch flush (exe or dec); kills any in-flight fetch return.
- `lsu_req` in 1: LSU ICCM access request.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_addr` in ADDR_W: LSU address.
- `lsu_wdata` in 32: store data.
- `lsu_wstrb` in 4: store byte enables.
- `lsu_gnt` out 1: LSU request accepted this cycle.
- `lsu_rdata` out 32: load return data.
- `lsu_rvalid` out 1: load data valid.
- `ldr_mode` in 1: loader takes ownership of the ICCM.
- `ldr_active` out 1: arbiter is in LOAD state.
- `ldr_wr` in 1: loader word write (honoured only in LOAD).
- `ldr_addr` in ADDR_W: loader address.
- `ldr_wdata` in 32: loader write data.
- `iccm_addr` out ADDR_W: ICCM address.
- `iccm_rd_en` out 1: ICCM read strobe.
- `iccm_wr_en` out 1: ICCM write strobe.
- `iccm_wr_data` out 32: ICCM write data.
- `iccm_wr_strb` out 4: ICCM byte enables.
- `iccm_rd_data` in 32: ICCM read data, valid 1 cycle after `iccm_rd_en`.

## Operation
**FSM states:** RUN, DRAIN, LOAD. Reset state is RUN.

- **RUN:**
  - If `ldr_mode` is set, go to DRAIN and issue no grant that cycle.
  - Otherwise, with `lsu_req`: grant LSU unless `ifu_req` is high and `lsu_consec == LSU_MAX_CONSEC`, in which case grant IFU.
  - Otherwise, grant IFU if `ifu_req`.
  - `ifu_stall` = `ifu_req` & ~IFU granted.
- **DRAIN:** one cycle with no grants, so any in-flight read returns. Then go to LOAD if `ldr_mode` is still high, else back to RUN.
- **LOAD:**
  - `ldr_active` = 1; `ifu_stall` = `ifu_req`; `lsu_gnt` = 0.
  - `ldr_wr` drives `iccm_wr_en` with `iccm_wr_strb` = 4'hF.
  - When `ldr_mode` drops, return to RUN on the next cycle.

**`lsu_consec` counter:**
- Width is clog2(`LSU_MAX_CONSEC`+1).
- Increments on each LSU grant while `ifu_req` is high; saturates at `LSU_MAX_CONSEC`.
- Clears on any IFU grant or when `ifu_req` is low.

**ICCM drive:**
- IFU grant: `iccm_addr` = `ifu_addr`, `iccm_rd_en` = 1.
- LSU load grant: `iccm_addr` = `lsu_addr`, `iccm_rd_en` = 1.
- LSU store grant: `iccm_addr` = `lsu_addr`, `iccm_wr_en` = 1, data and strobe from LSU.
- Idle: all strobes 0, address 0.

**Return routing:**
- A 2-bit owner register records the owner of a read granted in cycle N (IFU, LSU, none).
- In cycle N+1, `iccm_rd_data` goes combinationally to the owner's rdata and that owner's rvalid is asserted.
- Stores produce no rvalid.
- An IFU-owned return is suppressed when `ifu_flush` is high in cycle N or N+1.
- The non-owner's rdata output is held at 0.

## Timing
- **Reset values:** all outputs 0; FSM = RUN; counter = 0; owner = none.
- **Latency:** grant in cycle N → rvalid in cycle N+1.
- **Throughput:** one access per cycle in RUN.
- Grant and stall are combinational from the same-cycle requests.
- **Simultaneous `ldr_mode` and `lsu_req` in RUN:** LSU is not granted; the LSU keeps its request asserted until `lsu_gnt`.
- **`ifu_flush` with IFU granted in the same cycle:** the access is issued, but its return is dropped.
- **`rst_n` asserted in any state:** immediate return to reset values; in-flight data is discarded.

## Test plan
- **Fetch only:** `ifu_req`=1, addresses 0,4,8 → `iccm_rd_en` each cycle, `ifu_rvalid` one cycle later with the matching data, `ifu_stall`=0.
- **Fairness:** `lsu_req` held 6 cycles with `ifu_req`=1 and `LSU_MAX_CONSEC`=4 → LSU grants at cycles 0-3, IFU grant at cycle 4 (`ifu_stall`=0), LSU grant at cycle 5.
- **LSU store:** write 0xDEADBEEF with strb 4'b0011 at 0x100 → `iccm_wr_en`=1, strb 4'b0011, no `lsu_rvalid`. A following load of 0x100 returns the ICCM model value with `lsu_rvalid` at N+1.
- **Flush:** IFU grant at cycle N plus `ifu_flush` at N+1 → no `ifu_rvalid` at N+1, and `ifu_rdata`=0.
- **Loader sequence:** raise `ldr_mode` during a LSU read in flight → read returns (DRAIN), then `ldr_active`=1 and 3 `ldr_wr` writes reach the ICCM with strb F while `ifu_stall`=1. Drop `ldr_mode` → RUN the next cycle and fetch resumes.
- **Reset mid-LOAD:** pull `rst_n` low in LOAD → `ldr_active`, `iccm_wr_en`, and all valids drop to 0 asynchronously; after release the FSM is in RUN.
